// File: rtl/period_meter.sv
// rtl/period_meter.sv - measures the rising-edge period of a slow input in clk cycles; PERIOD_METER_DUTY_EN adds high_out
module period_meter #(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT     = 1000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             stalled
`ifdef PERIOD_METER_DUTY_EN
  ,
  output logic [CNT_W-1:0] high_out
`endif
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_out;
  logic                   hist;
  logic                   rise;
  logic                   rise_q;
  logic [CNT_W-1:0]       cnt;

  // SYNC_STAGES is expected to be 2 or 3; the chain shifts toward the top bit
  assign sync_out = sync[SYNC_STAGES-1];
  assign rise     = sync_out & ~hist;

  // Synchroniser chain, edge history and a registered edge strobe. The strobe
  // is registered so the counter and capture logic never see the sync output
  // directly; hist is the input level aligned with rise_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync   <= '0;
      hist   <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], sig_in};
      hist   <= sync_out;
      rise_q <= rise;
    end
  end

  // Period FSM: first edge arms, later edges report, a silent TIMEOUT disarms.
  // An edge landing on the timeout cycle takes priority and is reported.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      period_out   <= '0;
      period_valid <= 1'b0;
      stalled      <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rise_q) begin
            state <= MEASURE;
            cnt   <= ONE;
          end
        end
        MEASURE: begin
          if (rise_q) begin
            cnt          <= ONE;
            period_out   <= cnt;
            period_valid <= 1'b1;
            stalled      <= 1'b0;
          end else if (cnt == TIMEOUT_C) begin
            stalled <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PERIOD_METER_DUTY_EN
  logic [CNT_W-1:0] hcnt;

  // High-time counter, restarted on every edge and captured with period_out
  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt     <= '0;
      high_out <= '0;
    end else begin
      if (rise_q) begin
        hcnt <= ONE;
      end else if (hist && (hcnt < TIMEOUT_C)) begin
        hcnt <= hcnt + ONE;
      end
      if (rise_q && (state == MEASURE)) begin
        high_out <= hcnt;
      end
    end
  end
`else
  // Duty-cycle measurement is not built in this configuration
`endif

endmodule

// File: tb/tb_period_meter.sv
// tb/tb_period_meter.sv - table-driven and randomized bench for period_meter against an edge-time reference model
module tb_period_meter;

  localparam int CNT_W       = 32;
  localparam int TIMEOUT     = 50;
  localparam int SYNC_STAGES = 2;
  localparam int LAT         = SYNC_STAGES + 1;
  localparam int MAXC        = 8000;

  logic             clk = 1'b0;
  logic             reset;
  logic             sig_in;
  logic [CNT_W-1:0] period_out;
  logic             period_valid;
  logic             stalled;
`ifdef PERIOD_METER_DUTY_EN
  logic [CNT_W-1:0] high_out;
`endif

  period_meter #(
    .CNT_W(CNT_W),
    .TIMEOUT(TIMEOUT),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sig_in(sig_in),
    .period_out(period_out),
    .period_valid(period_valid),
    .stalled(stalled)
`ifdef PERIOD_METER_DUTY_EN
    ,
    .high_out(high_out)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit sig_log [0:MAXC-1];
  bit rst_log [0:MAXC-1];
  int floor_c  = 0;

  // reference model state: expected outputs for the current cycle
  bit          m_armed   = 1'b0;
  int          m_last    = 0;
  bit          m_valid   = 1'b0;
  int unsigned m_period  = 0;
  bit          m_stalled = 1'b0;
  int unsigned m_high    = 0;

  // observations of reports
  int          vcount     = 0;
  int          last_v_cyc = -1;
  int unsigned last_v_per = 0;

  typedef struct {
    int hi;
    int lo;
    int reps;
    int exp_period;
    int exp_high;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // input level as seen by the meter: anything at or before the last reset reads as 0
  function automatic bit sig_at(input int c);
    if (c <= floor_c || c < 0) return 1'b0;
    return sig_log[c];
  endfunction

  // a 0->1 change on sig_in in cycle c is detected in cycle c+LAT
  function automatic bit rise_at(input int c);
    return sig_at(c - LAT) & ~sig_at(c - LAT - 1);
  endfunction

  // outputs in cycle t+1 follow from what happened in cycle t
  task automatic model_advance(input int t);
    int h;
    m_valid = 1'b0;
    if (rst_log[t]) begin
      m_armed   = 1'b0;
      m_last    = 0;
      m_period  = 0;
      m_stalled = 1'b0;
      m_high    = 0;
    end else if (rise_at(t)) begin
      if (m_armed) begin
        m_valid   = 1'b1;
        m_period  = t - m_last;
        m_stalled = 1'b0;
        h = 0;
        for (int c = m_last - LAT; c <= t - LAT - 1; c++) h += sig_at(c);
        m_high = (h > TIMEOUT) ? TIMEOUT : h;
      end
      m_armed = 1'b1;
      m_last  = t;
    end else if (m_armed && (t - m_last == TIMEOUT)) begin
      m_stalled = 1'b1;
      m_armed   = 1'b0;
    end
  endtask

  task automatic step(input bit s, input bit r);
    @(posedge clk);
    cyc++;
    #1;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget cycle=%0d limit=%0d", cyc, MAXC);
      $fatal(1);
    end
    sig_in       = s;
    reset        = r;
    sig_log[cyc] = s;
    rst_log[cyc] = r;
    model_advance(cyc - 1);
    if (r) floor_c = cyc;
    @(negedge clk);
    check("valid", period_valid, m_valid);
    check("period", period_out, m_period);
    check("stalled", stalled, m_stalled);
`ifdef PERIOD_METER_DUTY_EN
    check("high", high_out, m_high);
`endif
    if (period_valid) begin
      vcount++;
      last_v_cyc = cyc;
      last_v_per = period_out;
    end
  endtask

  task automatic wave(input int hi, input int lo, input int reps);
    for (int k = 0; k < reps; k++) begin
      for (int i = 0; i < hi; i++) step(1'b1, 1'b0);
      for (int i = 0; i < lo; i++) step(1'b0, 1'b0);
    end
  endtask

  initial begin
    int vc0;
    int a_cyc;

    vecs[0] = '{hi: 5,  lo: 5,  reps: 5, exp_period: 10, exp_high: 5};
    vecs[1] = '{hi: 7,  lo: 13, reps: 4, exp_period: 20, exp_high: 7};
    vecs[2] = '{hi: 3,  lo: 3,  reps: 5, exp_period: 6,  exp_high: 3};
    vecs[3] = '{hi: 1,  lo: 1,  reps: 6, exp_period: 2,  exp_high: 1};
    vecs[4] = '{hi: 25, lo: 25, reps: 3, exp_period: 50, exp_high: 25};

    reset      = 1'b1;
    sig_in     = 1'b0;
    sig_log[0] = 1'b0;
    rst_log[0] = 1'b1;

    repeat (3) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check("reset_period", period_out, 0);
    check("reset_valid", period_valid, 0);
    check("reset_stalled", stalled, 0);

    // steady waves, including the minimum period and a period equal to TIMEOUT
    for (int v = 0; v < 5; v++) begin
      vc0 = vcount;
      wave(vecs[v].hi, vecs[v].lo, vecs[v].reps);
      check($sformatf("vec%0d_period", v), last_v_per, vecs[v].exp_period);
      check($sformatf("vec%0d_reported", v), (vcount - vc0 >= vecs[v].reps - 2), 1);
      check($sformatf("vec%0d_not_stalled", v), stalled, 0);
`ifdef PERIOD_METER_DUTY_EN
      check($sformatf("vec%0d_high", v), high_out, vecs[v].exp_high);
`endif
    end

    // stall: one rise then a long low; the rise still reports the 50-cycle period
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    vc0 = vcount;
    for (int i = 0; i < 50; i++) step(1'b0, 1'b0);
    check("stall_flag", stalled, 1);
    check("stall_no_valid", vcount - vc0, 0);
    check("stall_period_kept", period_out, 50);
    // two rises 8 apart: first re-arms, second reports
    vc0 = vcount;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    check("rearm_no_report", vcount - vc0, 0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
    check("rearm_period", last_v_per, 8);
    check("rearm_count", vcount - vc0, 1);
    check("rearm_stall_clear", stalled, 0);

    // reset in the middle of a 10-cycle wave
    wave(5, 5, 3);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check("midreset_period", period_out, 0);
    check("midreset_valid", period_valid, 0);
    check("midreset_stalled", stalled, 0);
    step(1'b0, 1'b0);
    vc0 = vcount;
    wave(5, 5, 1);
    check("midreset_first_rise_silent", vcount - vc0, 0);
    wave(5, 5, 1);
    check("midreset_first_report", last_v_per, 10);
    check("midreset_report_count", vcount - vc0, 1);

    // edge-to-strobe latency on a 10-cycle wave
    wave(5, 5, 2);
    step(1'b1, 1'b0);
    a_cyc = cyc;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    check("latency_cycle", last_v_cyc, a_cyc + SYNC_STAGES + 2);
    check("latency_period", last_v_per, 10);

    // randomized high/low times, some long enough to stall
    for (int k = 0; k < 40; k++) begin
      wave($urandom_range(1, 30), $urandom_range(1, 30), 1);
    end
    for (int i = 0; i < 60; i++) step(1'b0, 1'b0);
    check("random_end_stalled", stalled, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
